scale_ctrl: RTL and testbench
=============================

# scale_ctrl

Scale-mode controller and frame-buffer read-address sequencer for the camera display path. It cycles the display scale (1x, 2x, 8/3x) on a user button press, applies each change only at a frame boundary, and generates the 240x320 frame-buffer read address plus an in-window flag for every XVGA pixel. Its `scale_out` drives the downstream scale/blanking stage, and its `addr_out` drives the frame-buffer read port.

## Interface
Parameters:
- `SRC_W`, default 240: source frame width in pixels.
- `SRC_H`, default 320: source frame height in lines.
- `ADDR_W`, default 17: frame-buffer address width; must satisfy 2^ADDR_W >= SRC_W*SRC_H.

Ports:
- `clk_in`  input  1: pixel clock; one hcount step per cycle.
- `rst_n_in`  input  1: asynchronous active-low reset.
- `btn_in`  input  1: single-cycle pulse that requests the next scale mode. The pulse is already debounced.
- `hcount_in`  input  11: horizontal pixel counter, 0..1343, wraps to 0.
- `vcount_in`  input  10: vertical line counter, 0..805, advances when hcount wraps.
- `scale_out`  output  2: active scale mode. 00 = 1x, 01 = 2x, 10 = 8/3x, 11 = off.
- `pending_out`  output  1: a requested mode is waiting for the next frame start.
- `addr_out`  output  ADDR_W: frame-buffer read address for the pixel presented one cycle earlier.
- `in_window_out`  output  1: that pixel lies inside the active scaled window.

## Operation
- **Mode sequence.** Each `btn_in` pulse advances `next_scale` in the order 00 -> 01 -> 10 -> 00. Mode 11 is never selected by the button.
  - The first press copies `scale_out` into `next_scale`, advances it, and sets pending.
  - Further presses while pending advance `next_scale` again.
- **Frame start** is the cycle with `hcount_in==0` and `vcount_in==0`. On that cycle, if pending is set:
  - `scale_out` takes `next_scale` and pending clears.
  - The new mode governs this pixel's address and window.
- **Press on the frame-start cycle.** The apply uses the pre-press value. The press then re-arms pending and is applied at the following frame start.
- **Source coordinates**, with h = `hcount_in` and v = `vcount_in`:
  - 00: sx = h, sy = v.
  - 01: sx = h>>1, sy = v>>1.
  - 10: sx = floor(3h/8), sy = floor(3v/8).
- **Implementation constraint.** Source coordinates come from incremental accumulators with no multipliers:
  - The horizontal accumulator resets at h==0 and advances once per cycle.
  - The vertical accumulator resets at frame start and advances at each h==0 with v>0.
  - In mode 10, the fractional accumulator adds 3 per step and, when the sum is >=8, subtracts 8 and increments the coordinate.
- **Row base.** A row-base register adds `SRC_W` each time sy increments and resets to 0 at frame start. `addr = row_base + sx`.
- **Window.**
  - 00: h<240, v<320.
  - 01: h<480, v<640.
  - 10: h<640, v<853.
  - 11: never in window.
  - When out of window, `addr_out` holds 0.
- **Non-contiguous counters.** If hcount jumps by any step other than +1 or a wrap to 0, behaviour is undefined until the next frame start.

## Timing
- **Reset values:** `scale_out`=00, `next_scale`=00, `pending_out`=0, `addr_out`=0, `in_window_out`=0, all accumulators 0. Reset is asynchronous on assertion and takes effect on the first clock edge after release.
- **Latency:** `addr_out` and `in_window_out` are registered, one cycle after the corresponding `hcount_in`/`vcount_in`.
- **Pending:** `pending_out` rises the cycle after a press. It falls the cycle after the frame start that applies it.
- **Scale apply:** `scale_out` changes the cycle after frame start, aligned with the first `addr_out` of the new frame.
- **Reset mid-frame:** the block restarts in 1x. Addresses are correct from the next frame start.

## Configuration
- `SCALE_CTRL_MIRROR_EN`:
  - Defined: horizontal mirror, with sx replaced by (`SRC_W`-1-sx) in every mode. This compensates for the front-facing camera. Window and latency are unchanged.
  - Undefined: sx is used unmodified.

## Test plan
- **Reset:** assert `rst_n_in`=0 mid-line -> all outputs 0 immediately. After release, the frame runs in 1x: h=5, v=2 -> `addr_out`=485 one cycle later.
- **1x window edge:**
  - h=239, v=319 -> `addr_out`=76799, `in_window_out`=1.
  - h=240 -> `in_window_out`=0, `addr_out`=0.
- **Mode change at frame boundary:** one press mid-frame -> `pending_out`=1 and `scale_out` stays 00. At the next frame start -> `scale_out`=01, `pending_out`=0. Then h=7, v=3 -> `addr_out`=1*240+3=243.
- **8/3x arithmetic:** two presses from 00, then frame start -> `scale_out`=10.
  - h=639, v=852 -> sx=239, sy=319, `addr_out`=76799.
  - h=8, v=8 -> `addr_out`=3*240+3=723.
- **Simultaneous press and frame start:** pending target 01, with a press on the frame-start cycle -> `scale_out`=01 and `pending_out` stays 1 (target 10). The next frame start -> `scale_out`=10.
- **Mirror** (`SCALE_CTRL_MIRROR_EN` defined): 1x mode, h=0, v=0 -> `addr_out`=239.

Source files
------------

// File: rtl/scale_ctrl.sv
// scale_ctrl: display scale-mode controller and frame-buffer read-address
// sequencer. A button press cycles 1x -> 2x -> 8/3x, and the change takes
// effect at the next frame start. Source coordinates are built from
// incremental accumulators, so the block contains no multipliers.
// Optional feature macro: SCALE_CTRL_MIRROR_EN (horizontal mirror of sx).
module scale_ctrl #(
    parameter int SRC_W  = 240,
    parameter int SRC_H  = 320,
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              btn_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    output logic [1:0]        scale_out,
    output logic              pending_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              in_window_out
);

    typedef enum logic [1:0] {
        SCALE_1X  = 2'b00,
        SCALE_2X  = 2'b01,
        SCALE_83X = 2'b10,
        SCALE_OFF = 2'b11
    } scale_t;

    localparam logic [ADDR_W-1:0] SRC_W_A  = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] SRC_W_M1 = ADDR_W'(SRC_W - 1);

    localparam logic [11:0] WIN_H_1X  = 12'(SRC_W);
    localparam logic [11:0] WIN_H_2X  = 12'(2 * SRC_W);
    localparam logic [11:0] WIN_H_83X = 12'((8 * SRC_W) / 3);
    localparam logic [11:0] WIN_V_1X  = 12'(SRC_H);
    localparam logic [11:0] WIN_V_2X  = 12'(2 * SRC_H);
    localparam logic [11:0] WIN_V_83X = 12'((8 * SRC_H) / 3);

    // Mode-control state
    scale_t r_scale;
    scale_t r_next;
    logic   r_pending;
    scale_t w_scaleNext;
    scale_t w_nextNext;
    scale_t w_base;
    logic   w_pendingNext;

    // Accumulator state: values belonging to the previous pixel / line
    logic [10:0]       r_sx;
    logic [2:0]        r_hFrac;
    logic [9:0]        r_sy;
    logic [2:0]        r_vFrac;
    logic [ADDR_W-1:0] r_rowBase;

    // Accumulator values for the pixel currently on the inputs
    logic [10:0]       w_sx;
    logic [2:0]        w_hFrac;
    logic [3:0]        w_hSum;
    logic [9:0]        w_sy;
    logic [2:0]        w_vFrac;
    logic [3:0]        w_vSum;
    logic              w_syInc;
    logic [ADDR_W-1:0] w_rowBase;

    // Output datapath
    logic              w_frameStart;
    scale_t            w_mode;
    logic [ADDR_W-1:0] w_sxAddr;
    logic [ADDR_W-1:0] w_addr;
    logic              w_inWindow;
    logic [11:0]       w_h12;
    logic [11:0]       w_v12;

    function automatic scale_t advanceMode(input scale_t m);
        case (m)
            SCALE_1X: advanceMode = SCALE_2X;
            SCALE_2X: advanceMode = SCALE_83X;
            default:  advanceMode = SCALE_1X;
        endcase
    endfunction

    assign w_frameStart = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // A pending request governs the frame-start pixel itself, not just the next one
    assign w_mode = (w_frameStart && r_pending) ? r_next : r_scale;

    assign w_h12 = {1'b0, hcount_in};
    assign w_v12 = {2'b00, vcount_in};

    // Mode state register: active scale, queued scale and pending flag
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_scale   <= SCALE_1X;
            r_next    <= SCALE_1X;
            r_pending <= 1'b0;
        end else begin
            r_scale   <= w_scaleNext;
            r_next    <= w_nextNext;
            r_pending <= w_pendingNext;
        end
    end

    // Mode next-state: apply at frame start first, then let a press re-arm from the newest target
    always_comb begin
        w_scaleNext   = r_scale;
        w_nextNext    = r_next;
        w_pendingNext = r_pending;
        w_base        = r_pending ? r_next : r_scale;
        if (w_frameStart && r_pending) begin
            w_scaleNext   = r_next;
            w_pendingNext = 1'b0;
        end
        if (btn_in) begin
            w_nextNext    = advanceMode(w_base);
            w_pendingNext = 1'b1;
        end
    end

    // Horizontal accumulator: restart at h==0, otherwise one step per pixel
    always_comb begin
        w_sx    = r_sx;
        w_hFrac = r_hFrac;
        w_hSum  = {1'b0, r_hFrac} + 4'd3;
        if (hcount_in == 11'd0) begin
            w_sx    = 11'd0;
            w_hFrac = 3'd0;
        end else begin
            case (w_mode)
                SCALE_1X: w_sx = r_sx + 11'd1;
                SCALE_2X: if (!hcount_in[0]) w_sx = r_sx + 11'd1;
                SCALE_83X: begin
                    // Bit 3 of the sum is the ">= 8" carry; dropping it is the subtract-8
                    w_hFrac = w_hSum[2:0];
                    if (w_hSum[3]) w_sx = r_sx + 11'd1;
                end
                default: w_sx = r_sx;
            endcase
        end
    end

    // Vertical accumulator and row base: restart at frame start, step at each later line start
    always_comb begin
        w_sy      = r_sy;
        w_vFrac   = r_vFrac;
        w_rowBase = r_rowBase;
        w_syInc   = 1'b0;
        w_vSum    = {1'b0, r_vFrac} + 4'd3;
        if (w_frameStart) begin
            w_sy      = 10'd0;
            w_vFrac   = 3'd0;
            w_rowBase = '0;
        end else if (hcount_in == 11'd0) begin
            case (w_mode)
                SCALE_1X: w_syInc = 1'b1;
                SCALE_2X: w_syInc = !vcount_in[0];
                SCALE_83X: begin
                    w_vFrac = w_vSum[2:0];
                    w_syInc = w_vSum[3];
                end
                default: w_syInc = 1'b0;
            endcase
            if (w_syInc) begin
                w_sy      = r_sy + 10'd1;
                w_rowBase = r_rowBase + SRC_W_A;
            end
        end
    end

    // Accumulator registers carry this pixel's values forward to the next pixel
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sx      <= '0;
            r_hFrac   <= '0;
            r_sy      <= '0;
            r_vFrac   <= '0;
            r_rowBase <= '0;
        end else begin
            r_sx      <= w_sx;
            r_hFrac   <= w_hFrac;
            r_sy      <= w_sy;
            r_vFrac   <= w_vFrac;
            r_rowBase <= w_rowBase;
        end
    end

`ifdef SCALE_CTRL_MIRROR_EN
    assign w_sxAddr = SRC_W_M1 - ADDR_W'(w_sx);
`else
    assign w_sxAddr = ADDR_W'(w_sx);
`endif

    assign w_addr = w_rowBase + w_sxAddr;

    // Window test on the raw counters against the scaled source size
    always_comb begin
        w_inWindow = 1'b0;
        case (w_mode)
            SCALE_1X:  w_inWindow = (w_h12 < WIN_H_1X)  && (w_v12 < WIN_V_1X);
            SCALE_2X:  w_inWindow = (w_h12 < WIN_H_2X)  && (w_v12 < WIN_V_2X);
            SCALE_83X: w_inWindow = (w_h12 < WIN_H_83X) && (w_v12 < WIN_V_83X);
            default:   w_inWindow = 1'b0;
        endcase
    end

    // Registered address and window flag; address parks at 0 outside the window
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_out      <= '0;
            in_window_out <= 1'b0;
        end else begin
            addr_out      <= w_inWindow ? w_addr : '0;
            in_window_out <= w_inWindow;
        end
    end

    assign scale_out   = r_scale;
    assign pending_out = r_pending;

endmodule

// File: tb/tb_scale_ctrl.sv
// Directed testbench for scale_ctrl. Counters are driven directly: a target
// pixel is reached by a frame start, a run of line starts down to the wanted
// line, then a run of pixels along it.
module tb_scale_ctrl;

    logic        clk_in;
    logic        rst_n_in;
    logic        btn_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [1:0]  scale_out;
    logic        pending_out;
    logic [16:0] addr_out;
    logic        in_window_out;

    int totalCount;
    int badCount;

    scale_ctrl #(.SRC_W(240), .SRC_H(320), .ADDR_W(17)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .btn_in        (btn_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .scale_out     (scale_out),
        .pending_out   (pending_out),
        .addr_out      (addr_out),
        .in_window_out (in_window_out)
    );

    // Free-running pixel clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Expected address for a given source row/column, mirrored when the option is built in
    function automatic int expAddr(input int sy, input int sx);
`ifdef SCALE_CTRL_MIRROR_EN
        expAddr = sy * 240 + (239 - sx);
`else
        expAddr = sy * 240 + sx;
`endif
    endfunction

    // Compare one observed value against its expected value and tally the result
    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalCount++;
        if (observed != expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one pixel for one clock; outputs are settled for it 1 time unit after the edge
    task automatic applyStimulus(input int h, input int v, input logic btn);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        btn_in    = btn;
        @(posedge clk_in);
        #1;
        btn_in = 1'b0;
    endtask

    // Walk from a frame start down to line v, then along it to pixel h
    task automatic gotoPixel(input int h, input int v);
        applyStimulus(0, 0, 1'b0);
        for (int i = 1; i <= v; i++) applyStimulus(0, i, 1'b0);
        for (int j = 1; j <= h; j++) applyStimulus(j, v, 1'b0);
    endtask

    // Main directed sequence
    initial begin
        totalCount = 0;
        badCount   = 0;
        rst_n_in   = 1'b0;
        btn_in     = 1'b0;
        hcount_in  = '0;
        vcount_in  = '0;

        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("rst scale", scale_out, 0);
        checkOutput("rst pending", pending_out, 0);
        checkOutput("rst addr", addr_out, 0);
        checkOutput("rst window", in_window_out, 0);
        rst_n_in = 1'b1;

        gotoPixel(5, 2);
        checkOutput("1x addr h5 v2", addr_out, expAddr(2, 5));
        checkOutput("1x window h5 v2", in_window_out, 1);

`ifdef SCALE_CTRL_MIRROR_EN
        gotoPixel(0, 0);
        checkOutput("mirror addr h0 v0", addr_out, 239);
`endif

        // 1x window corner and first pixel past it
        gotoPixel(239, 319);
        checkOutput("1x addr corner", addr_out, expAddr(319, 239));
        checkOutput("1x window corner", in_window_out, 1);
        applyStimulus(240, 319, 1'b0);
        checkOutput("1x window h240", in_window_out, 0);
        checkOutput("1x addr h240", addr_out, 0);

        // A mid-frame press queues 2x without disturbing the current frame
        applyStimulus(300, 319, 1'b1);
        checkOutput("press pending", pending_out, 1);
        checkOutput("press scale held", scale_out, 0);
        applyStimulus(301, 319, 1'b0);
        checkOutput("press addr out of window", addr_out, 0);

        applyStimulus(0, 0, 1'b0);
        checkOutput("apply scale 2x", scale_out, 1);
        checkOutput("apply pending clr", pending_out, 0);
        gotoPixel(7, 3);
        checkOutput("2x addr h7 v3", addr_out, expAddr(1, 3));

        gotoPixel(479, 639);
        checkOutput("2x addr corner", addr_out, expAddr(319, 239));
        checkOutput("2x window corner", in_window_out, 1);
        applyStimulus(480, 639, 1'b0);
        checkOutput("2x window h480", in_window_out, 0);

        // Two presses from 2x wrap the target round to 1x
        applyStimulus(500, 639, 1'b1);
        applyStimulus(501, 639, 1'b1);
        checkOutput("wrap pending", pending_out, 1);
        applyStimulus(0, 0, 1'b0);
        checkOutput("wrap scale 1x", scale_out, 0);

        // Two presses from 1x select 8/3x
        applyStimulus(10, 0, 1'b1);
        applyStimulus(11, 0, 1'b1);
        checkOutput("83 scale held", scale_out, 0);
        gotoPixel(639, 852);
        checkOutput("83 scale", scale_out, 2);
        checkOutput("83 addr corner", addr_out, expAddr(319, 239));
        checkOutput("83 window corner", in_window_out, 1);
        applyStimulus(640, 852, 1'b0);
        checkOutput("83 window h640", in_window_out, 0);
        checkOutput("83 addr h640", addr_out, 0);
        gotoPixel(8, 8);
        checkOutput("83 addr h8 v8", addr_out, expAddr(3, 3));

        // Queue 2x, then press again on the very frame-start cycle
        applyStimulus(20, 8, 1'b1);
        applyStimulus(21, 8, 1'b1);
        applyStimulus(0, 0, 1'b1);
        checkOutput("simul scale 2x", scale_out, 1);
        checkOutput("simul pending kept", pending_out, 1);
        checkOutput("simul addr h0 v0", addr_out, expAddr(0, 0));
        gotoPixel(8, 8);
        checkOutput("simul scale 83", scale_out, 2);
        checkOutput("simul pending clr", pending_out, 0);
        checkOutput("simul addr h8 v8", addr_out, expAddr(3, 3));

        // Asynchronous reset in the middle of a clock period
        applyStimulus(100, 8, 1'b1);
        checkOutput("pre-reset pending", pending_out, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("async scale", scale_out, 0);
        checkOutput("async pending", pending_out, 0);
        checkOutput("async addr", addr_out, 0);
        checkOutput("async window", in_window_out, 0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        gotoPixel(5, 2);
        checkOutput("post-reset scale", scale_out, 0);
        checkOutput("post-reset addr", addr_out, expAddr(2, 5));

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
